// File: rtl/fv_dispatch_pkg.sv
// Shared types and default parameters for the feature-vector bank dispatcher.
// The request struct fields are sized for the default parameter set.
package fv_dispatch_pkg;

    localparam int unsigned DEF_NUM_BANKS  = 4;
    localparam int unsigned DEF_NUM_PE     = 4;
    localparam int unsigned DEF_FV_WIDTH   = 16;
    localparam int unsigned DEF_FV_WORDS   = 4;
    localparam int unsigned DEF_BANK_DEPTH = 256;
    localparam int unsigned DEF_REQ_DEPTH  = 8;

    localparam int unsigned DEF_TAG_W = $clog2(DEF_NUM_PE);
    localparam int unsigned DEF_FVI_W = $clog2(DEF_NUM_BANKS * DEF_BANK_DEPTH / DEF_FV_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } fv_bank_state_e;

    typedef struct packed {
        logic [DEF_TAG_W-1:0] pe_tag;
        logic [DEF_FVI_W-1:0] fv_idx;
    } fv_req_t;

endpackage

// File: rtl/fv_bank_dispatch_if.sv
// Request handshake bundle: the producer drives master, the dispatcher is slave.
interface fv_bank_dispatch_if #(
    parameter int unsigned TAG_W = 2,
    parameter int unsigned FVI_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [TAG_W-1:0] req_pe_tag;
    logic [FVI_W-1:0] req_fv_idx;

    modport master (output req_valid, req_pe_tag, req_fv_idx, input req_ready);
    modport slave  (input req_valid, req_pe_tag, req_fv_idx, output req_ready);
endinterface

// File: rtl/fv_bank_reader.sv
// Per-bank reader: FSM, beat counter, registered SRAM pins, preload muxing
// and the tag of the PE this bank currently owns.
module fv_bank_reader
    import fv_dispatch_pkg::*;
#(
    parameter int unsigned FV_WIDTH = DEF_FV_WIDTH,
    parameter int unsigned FV_WORDS = DEF_FV_WORDS,
    parameter int unsigned AW       = $clog2(DEF_BANK_DEPTH),
    parameter int unsigned TAG_W    = DEF_TAG_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                disp_i,
    input  logic [AW-1:0]       base_i,
    input  logic [TAG_W-1:0]    tag_i,
    input  logic                ld_fire_i,
    input  logic [AW-1:0]       ld_addr_i,
    input  logic [FV_WIDTH-1:0] ld_data_i,
    output logic                idle_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic                rvld_o,
    output logic                rlast_o,
    output logic                cen_o,
    output logic                wen_o,
    output logic [AW-1:0]       a_o,
    output logic [FV_WIDTH-1:0] d_o
);
    localparam int unsigned     BEAT_W    = (FV_WORDS > 1) ? $clog2(FV_WORDS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FV_WORDS - 1);

    fv_bank_state_e      state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [TAG_W-1:0]    tag_q;
    logic                cen_q, wen_q, rvld_q, rlast_q;
    logic [AW-1:0]       a_q;
    logic [FV_WIDTH-1:0] d_q;

    // Bank FSM; SRAM pins are registered so beat k is on the pins at D+1+k.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            tag_q   <= '0;
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            a_q     <= '0;
            d_q     <= '0;
            rvld_q  <= 1'b0;
            rlast_q <= 1'b0;
        end else begin
            // A read on the pins this cycle returns sram_q next cycle.
            rvld_q  <= (state_q == ISSUE);
            rlast_q <= (state_q == ISSUE) && (beat_q == LAST_BEAT);
            unique case (state_q)
                IDLE: begin
                    cen_q <= 1'b1;
                    wen_q <= 1'b1;
                    if (ld_fire_i) begin
                        cen_q <= 1'b0;
                        wen_q <= 1'b0;
                        a_q   <= ld_addr_i;
                        d_q   <= ld_data_i;
                    end else if (disp_i) begin
                        state_q <= ISSUE;
                        beat_q  <= '0;
                        tag_q   <= tag_i;
                        cen_q   <= 1'b0;
                        a_q     <= base_i;
                    end
                end
                ISSUE: begin
                    if (beat_q == LAST_BEAT) begin
                        state_q <= DRAIN;
                        cen_q   <= 1'b1;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                        a_q    <= a_q + 1'b1;
                    end
                end
                DRAIN:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign idle_o  = (state_q == IDLE);
    assign tag_o   = tag_q;
    assign rvld_o  = rvld_q;
    assign rlast_o = rlast_q;
    assign cen_o   = cen_q;
    assign wen_o   = wen_q;
    assign a_o     = a_q;
    assign d_o     = d_q;
endmodule

// File: rtl/fv_bank_dispatch.sv
// Feature-vector bank dispatcher: request queue, head-of-line dispatch with
// per-PE ownership, preload arbitration and the bank-to-PE output crossbar.
// Optional FV_DISPATCH_PERF_EN adds saturating dispatch/stall counters.
module fv_bank_dispatch
    import fv_dispatch_pkg::*;
#(
    parameter int unsigned NUM_BANKS  = DEF_NUM_BANKS,
    parameter int unsigned NUM_PE     = DEF_NUM_PE,
    parameter int unsigned FV_WIDTH   = DEF_FV_WIDTH,
    parameter int unsigned FV_WORDS   = DEF_FV_WORDS,
    parameter int unsigned BANK_DEPTH = DEF_BANK_DEPTH,
    parameter int unsigned REQ_DEPTH  = DEF_REQ_DEPTH,
    localparam int unsigned TAG_W = $clog2(NUM_PE),
    localparam int unsigned AW    = $clog2(BANK_DEPTH),
    localparam int unsigned FVI_W = $clog2(NUM_BANKS * BANK_DEPTH / FV_WORDS),
    localparam int unsigned BW    = $clog2(NUM_BANKS)
) (
    input  logic                               clk,
    input  logic                               reset,
    fv_bank_dispatch_if.slave                  req_if,
    input  logic [FVI_W-1:0]                   num_fv,
    input  logic                               ld_valid,
    output logic                               ld_ready,
    input  logic [BW-1:0]                      ld_bank,
    input  logic [AW-1:0]                      ld_addr,
    input  logic [FV_WIDTH-1:0]                ld_data,
    output logic [NUM_BANKS-1:0]               sram_cen,
    output logic [NUM_BANKS-1:0]               sram_wen,
    output logic [NUM_BANKS-1:0][AW-1:0]       sram_a,
    output logic [NUM_BANKS-1:0][FV_WIDTH-1:0] sram_d,
    input  logic [NUM_BANKS-1:0][FV_WIDTH-1:0] sram_q,
    output logic [NUM_PE-1:0]                  pe_valid,
    output logic [NUM_PE-1:0]                  pe_last,
    output logic [NUM_PE-1:0][FV_WIDTH-1:0]    pe_data,
    output logic                               err_valid,
    output logic [TAG_W-1:0]                   err_pe_tag
`ifdef FV_DISPATCH_PERF_EN
    ,
    output logic [31:0]                        perf_dispatched,
    output logic [31:0]                        perf_stall
`endif
);
    localparam int unsigned PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(REQ_DEPTH + 1);

    fv_req_t          fifo_q [REQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [FVI_W-1:0] num_fv_q;
    logic             push, pop, head_vld, head_oor, dispatch_ok;
    fv_req_t          head;
    logic [TAG_W-1:0] head_tag;
    logic [FVI_W-1:0] head_idx;
    logic [BW-1:0]    head_bank;
    logic [AW-1:0]    head_base;

    logic [NUM_BANKS-1:0]            bank_idle, bank_rvld, bank_rlast, bank_disp, ld_fire;
    logic [NUM_BANKS-1:0][TAG_W-1:0] bank_tag;
    logic [NUM_PE-1:0]               pe_owned, xb_valid, xb_last;
    logic [NUM_PE-1:0][FV_WIDTH-1:0] xb_data;
    logic [NUM_PE-1:0]               pe_valid_q, pe_last_q;
    logic [NUM_PE-1:0][FV_WIDTH-1:0] pe_data_q;
    logic                            err_valid_q;
    logic [TAG_W-1:0]                err_tag_q;

    assign req_if.req_ready = (count_q < CNT_W'(REQ_DEPTH));
    assign push     = req_if.req_valid && req_if.req_ready;
    assign head     = fifo_q[rd_ptr_q];
    assign head_vld = (count_q != '0);
    assign head_tag = TAG_W'(head.pe_tag);
    assign head_idx = FVI_W'(head.fv_idx);
    assign head_oor = (head_idx >= num_fv_q);
    assign head_bank = head_idx[BW-1:0];
    assign head_base = AW'((head_idx >> BW) * FV_WORDS);
    assign ld_ready = bank_idle[ld_bank];

    // Request storage; count_q qualifies every read so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{pe_tag: DEF_TAG_W'(req_if.req_pe_tag),
                                  fv_idx: DEF_FVI_W'(req_if.req_fv_idx)};
        end
    end

    // Registering num_fv makes a change apply to the next cycle's head.
    always_ff @(posedge clk) begin
        num_fv_q <= num_fv;
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(REQ_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(REQ_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    // Ownership, load priority and head dispatch decision.
    always_comb begin
        pe_owned = '0;
        ld_fire  = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (!bank_idle[b]) pe_owned[bank_tag[b]] = 1'b1;
            ld_fire[b] = ld_valid && bank_idle[b] && (ld_bank == BW'(b));
        end
        dispatch_ok = head_vld && !head_oor && bank_idle[head_bank]
                      && !ld_fire[head_bank] && !pe_owned[head_tag];
        pop = head_vld && (head_oor || dispatch_ok);
        bank_disp = '0;
        bank_disp[head_bank] = dispatch_ok;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        fv_bank_reader #(
            .FV_WIDTH (FV_WIDTH),
            .FV_WORDS (FV_WORDS),
            .AW       (AW),
            .TAG_W    (TAG_W)
        ) u_reader (
            .clk       (clk),
            .reset     (reset),
            .disp_i    (bank_disp[b]),
            .base_i    (head_base),
            .tag_i     (head_tag),
            .ld_fire_i (ld_fire[b]),
            .ld_addr_i (ld_addr),
            .ld_data_i (ld_data),
            .idle_o    (bank_idle[b]),
            .tag_o     (bank_tag[b]),
            .rvld_o    (bank_rvld[b]),
            .rlast_o   (bank_rlast[b]),
            .cen_o     (sram_cen[b]),
            .wen_o     (sram_wen[b]),
            .a_o       (sram_a[b]),
            .d_o       (sram_d[b])
        );
    end

    // Crossbar: ownership guarantees at most one bank returns data per PE.
    always_comb begin
        xb_valid = '0;
        xb_last  = '0;
        xb_data  = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (bank_rvld[b]) begin
                xb_valid[bank_tag[b]] = 1'b1;
                xb_last[bank_tag[b]]  = bank_rlast[b];
                xb_data[bank_tag[b]]  = sram_q[b];
            end
        end
    end

    // Registered PE outputs and out-of-range drop pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            pe_valid_q  <= '0;
            pe_last_q   <= '0;
            pe_data_q   <= '0;
            err_valid_q <= 1'b0;
            err_tag_q   <= '0;
        end else begin
            pe_valid_q  <= xb_valid;
            pe_last_q   <= xb_last;
            pe_data_q   <= xb_data;
            err_valid_q <= head_vld && head_oor;
            if (head_vld && head_oor) err_tag_q <= head_tag;
        end
    end

    assign pe_valid   = pe_valid_q;
    assign pe_last    = pe_last_q;
    assign pe_data    = pe_data_q;
    assign err_valid  = err_valid_q;
    assign err_pe_tag = err_tag_q;

`ifdef FV_DISPATCH_PERF_EN
    logic [31:0] perf_disp_q, perf_stall_q;

    // Saturating dispatch and stalled-head counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_disp_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (dispatch_ok && (perf_disp_q != '1)) perf_disp_q <= perf_disp_q + 32'd1;
            if (head_vld && !head_oor && !dispatch_ok && (perf_stall_q != '1))
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_dispatched = perf_disp_q;
    assign perf_stall      = perf_stall_q;
`endif
endmodule
